game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer that owns the roam/battle datapaths.
- Decides which screen is active: title, roam, battle intro, battle, result, game over, victory.
- Drives the is_roam gate of the roam screen and the cur_battle index (0-4). Consumes start_battle from roam and done/won from the battle engine.
- Uses frame-rate timers for intro/result screens, and ENTER key-press edges to leave the title and end screens.

Parameters:
NUM_BATTLES, 5, number of elite battles; cur_battle range 0..NUM_BATTLES-1
INTRO_FRAMES, 60, frame edges spent in INTRO before BATTLE (1..255)
RESULT_FRAMES, 90, frame edges spent in RESULT before next state (1..255)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  vertical-sync-rate clock; sampled on Clk, rising edge detected internally
keycode  in  8  current keyboard scancode (ENTER = 8'h28)
start_battle  in  1  roam request to fight the current elite
battle_done  in  1  battle engine finished (level, held or pulsed)
battle_won  in  1  valid with battle_done; 1 = player won
is_title  out  1  title screen active
is_roam  out  1  roam screen active; low holds the trainer at spawn
is_battle  out  1  battle engine active (INTRO or BATTLE state)
is_end  out  1  GAME_OVER or VICTORY screen active
player_won  out  1  in end screens: 1 = VICTORY, 0 = GAME_OVER
cur_battle  out  3  current elite index
battle_begin  out  1  one-Clk pulse on entry to BATTLE
fade_level  out  4  screen fade amount, 0 = none (see Optional Feature)

Behaviour:
Reset:
- Synchronous and active-high, on posedge Clk. Overrides all other inputs in the same cycle.
- On reset: state=TITLE, is_title=1, all other flags=0, cur_battle=0, battle_begin=0, fade_level=0, timer=0, won latch=0.
- Reset in any state, including mid-battle, returns to TITLE.

Edge detection:
- frame_edge: frame_clk registered twice, pulse = cur & ~prev. Pulse appears 1 Clk after the edge is sampled.
- enter_press: (keycode==8'h28) & ~(prev keycode==8'h28). A held key yields exactly one press.

State transitions (all registered, one transition per Clk at most):
- TITLE: enter_press -> ROAM; cur_battle<=0.
- ROAM:
  - start_battle -> INTRO; timer<=INTRO_FRAMES.
  - Any other input is ignored.
- INTRO:
  - On each frame_edge, timer decrements.
  - On a frame_edge with timer==1 -> BATTLE. battle_begin=1 for exactly that next Clk.
- BATTLE: battle_done -> RESULT; won<=battle_won; timer<=RESULT_FRAMES.
- RESULT: on a frame_edge with timer==1:
  - won=0 -> GAME_OVER.
  - won=1 and cur_battle==NUM_BATTLES-1 -> VICTORY.
  - otherwise cur_battle<=cur_battle+1 -> ROAM.
- GAME_OVER / VICTORY: enter_press -> TITLE; cur_battle<=0.

Output decode and flag rules:
- Output flags are a Moore decode of the state and are mutually exclusive, except is_battle, which covers both INTRO and BATTLE.
- player_won=won in the end states, 0 elsewhere.
- start_battle outside ROAM is ignored. battle_done/battle_won outside BATTLE are ignored.
- enter_press in ROAM, INTRO, BATTLE or RESULT is ignored.
- The ENTER keypress that triggers start_battle inside roam does not affect this block.
- Leaving ROAM always drops is_roam, so the trainer respawns at its start point on the next roam entry. This is intended.

Arithmetic:
- Timer is 8 bits and saturates at 0; it never wraps.
- cur_battle never exceeds NUM_BATTLES-1; no wrap.

Optional Feature:
Macro FLOW_FADE_EN.
- Defined:
  - In INTRO, fade_level starts at 0 and increments by 1 per frame_edge, saturating at 15.
  - On entry to ROAM from RESULT, fade_level loads 15 and decrements by 1 per frame_edge, saturating at 0.
  - In all other states fade_level is 0.
  - The fade counter is independent of the state timer.
- Not defined: fade_level is constant 0 and the fade counter logic is absent.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [2:0] game_state_t {TITLE, ROAM, INTRO, BATTLE, RESULT, GAME_OVER, VICTORY}
  - KEY_ENTER=8'h28
  - NUM_ELITES=5
- Sub-module frame_timer. Ports: Clk, Reset, frame_clk, load, load_val[7:0]. Outputs: frame_edge, expire (frame_edge & count==1), count[7:0].
- The fade counter reuses frame_edge from frame_timer.

Test Plan:
(Bench uses INTRO_FRAMES=3, RESULT_FRAMES=2.)
1. Reset held 2 Clk mid-BATTLE -> next Clk is_title=1, cur_battle=0, is_battle=0, battle_begin=0.
2. From TITLE, hold keycode=8'h28 for 10 Clk -> one transition to ROAM. Release and press again -> stays ROAM.
3. In ROAM, pulse start_battle -> INTRO. After exactly 3 frame_edges -> BATTLE, with battle_begin high for 1 Clk.
4. In BATTLE, battle_done=1, battle_won=1, cur_battle=2 -> RESULT. After 2 frame_edges -> ROAM with cur_battle=3 and is_roam=1.
5. cur_battle=4 and a won battle -> VICTORY, player_won=1. A lost battle at cur_battle=1 -> GAME_OVER, player_won=0. ENTER -> TITLE, cur_battle=0.
6. FLOW_FADE_EN defined: in INTRO, after 20 frame_edges fade_level=15. On the RESULT->ROAM return, fade_level goes 15,14,... and reaches 0 after 15 frame_edges. Macro undefined: fade_level always 0.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game flow sequencer.
// Screen states, the ENTER scancode, the elite count and small fade helpers.
package game_pkg;

    // Screens the sequencer can be on; exactly one is active at a time.
    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        ROAM      = 3'd1,
        INTRO     = 3'd2,
        BATTLE    = 3'd3,
        RESULT    = 3'd4,
        GAME_OVER = 3'd5,
        VICTORY   = 3'd6
    } game_state_t;

    // Keyboard scancode of the ENTER key.
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Number of elite battles between the title and the victory screen.
    localparam int NUM_ELITES = 5;

    // Fully faded screen.
    localparam logic [3:0] FADE_MAX = 4'd15;

    // Fade counter step up, holding at FADE_MAX.
    function automatic logic [3:0] fade_up(input logic [3:0] lvl);
        return (lvl == FADE_MAX) ? FADE_MAX : lvl + 4'd1;
    endfunction

    // Fade counter step down, holding at zero.
    function automatic logic [3:0] fade_down(input logic [3:0] lvl);
        return (lvl == 4'd0) ? 4'd0 : lvl - 4'd1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame-rate timer: detects rising edges of the vertical-sync clock in the
// Clk domain and counts a loadable number of those edges down to zero.
// expire marks the frame edge on which the count leaves 1.
module frame_timer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       frame_edge,
    output logic       expire,
    output logic [7:0] count
);

    logic fc_cur;
    logic fc_prev;

    // Two-stage capture of frame_clk; the edge pulse is cur & ~prev.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_cur  <= 1'b0;
            fc_prev <= 1'b0;
        end else begin
            fc_cur  <= frame_clk;
            fc_prev <= fc_cur;
        end
    end

    assign frame_edge = fc_cur & ~fc_prev;

    // Down counter: load wins over a same-cycle edge; holds at zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (frame_edge && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign expire = frame_edge & (count == 8'd1);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: picks the active screen (title, roam, battle
// intro, battle, result, game over, victory), tracks which elite is next and
// drives the per-screen enable flags.
// Optional screen fade counter is built when FLOW_FADE_EN is defined;
// otherwise fade_level is tied to zero.
//
// Handshake: start_battle is honoured only in ROAM, battle_done/battle_won
// only in BATTLE; each is a level sampled once per Clk, so a held level and a
// one-cycle pulse behave the same. ENTER acts on its press edge only.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_BATTLES   = NUM_ELITES,
    parameter int INTRO_FRAMES  = 60,
    parameter int RESULT_FRAMES = 90
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       start_battle,
    input  logic       battle_done,
    input  logic       battle_won,
    output logic       is_title,
    output logic       is_roam,
    output logic       is_battle,
    output logic       is_end,
    output logic       player_won,
    output logic [2:0] cur_battle,
    output logic       battle_begin,
    output logic [3:0] fade_level
);

    localparam logic [7:0] INTRO_LOAD  = 8'(INTRO_FRAMES);
    localparam logic [7:0] RESULT_LOAD = 8'(RESULT_FRAMES);
    localparam logic [2:0] LAST_BATTLE = 3'(NUM_BATTLES - 1);

    game_state_t state;
    game_state_t state_next;

    logic [2:0] cur_q;
    logic [2:0] cur_next;
    logic       won_q;
    logic       won_next;
    logic       begin_q;

    logic       key_prev;
    logic       is_enter;
    logic       enter_press;

    logic       timer_load;
    logic [7:0] timer_load_val;
    logic       frame_edge;
    logic       timer_expire;
    logic [7:0] timer_count;
    logic       timer_done;

    // Screen timer shared by INTRO and RESULT.
    frame_timer u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .load       (timer_load),
        .load_val   (timer_load_val),
        .frame_edge (frame_edge),
        .expire     (timer_expire),
        .count      (timer_count)
    );

    // A timer that is already empty when an edge arrives also ends the
    // screen, so a zero frame count cannot lock the game in INTRO/RESULT.
    assign timer_done = timer_expire | (frame_edge & (timer_count == 8'd0));

    // ENTER press edge: a held key gives a single press.
    assign is_enter    = (keycode == KEY_ENTER);
    assign enter_press = is_enter & ~key_prev;

    // Next-state, next elite index, won latch and timer load decode.
    always_comb begin
        state_next     = state;
        cur_next       = cur_q;
        won_next       = won_q;
        timer_load     = 1'b0;
        timer_load_val = 8'd0;
        case (state)
            TITLE: begin
                if (enter_press) begin
                    state_next = ROAM;
                    cur_next   = 3'd0;
                end
            end
            ROAM: begin
                if (start_battle) begin
                    state_next     = INTRO;
                    timer_load     = 1'b1;
                    timer_load_val = INTRO_LOAD;
                end
            end
            INTRO: begin
                if (timer_done) begin
                    state_next = BATTLE;
                end
            end
            BATTLE: begin
                if (battle_done) begin
                    state_next     = RESULT;
                    won_next       = battle_won;
                    timer_load     = 1'b1;
                    timer_load_val = RESULT_LOAD;
                end
            end
            RESULT: begin
                if (timer_done) begin
                    if (!won_q) begin
                        state_next = GAME_OVER;
                    end else if (cur_q == LAST_BATTLE) begin
                        state_next = VICTORY;
                    end else begin
                        state_next = ROAM;
                        cur_next   = cur_q + 3'd1;
                    end
                end
            end
            GAME_OVER, VICTORY: begin
                if (enter_press) begin
                    state_next = TITLE;
                    cur_next   = 3'd0;
                end
            end
            default: begin
                state_next = TITLE;
                cur_next   = 3'd0;
            end
        endcase
    end

    // State, elite index, won latch, key history and battle_begin pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= TITLE;
            cur_q    <= 3'd0;
            won_q    <= 1'b0;
            begin_q  <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            state    <= state_next;
            cur_q    <= cur_next;
            won_q    <= won_next;
            begin_q  <= (state == INTRO) && (state_next == BATTLE);
            key_prev <= is_enter;
        end
    end

`ifdef FLOW_FADE_EN
    logic [3:0] fade_q;

    // Fade: ramps up through INTRO, ramps down after returning to ROAM from
    // RESULT, zero everywhere else. Any screen change restarts it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fade_q <= 4'd0;
        end else if (state_next != state) begin
            fade_q <= ((state == RESULT) && (state_next == ROAM)) ? FADE_MAX : 4'd0;
        end else begin
            case (state)
                INTRO:   if (frame_edge) fade_q <= fade_up(fade_q);
                ROAM:    if (frame_edge) fade_q <= fade_down(fade_q);
                default: fade_q <= 4'd0;
            endcase
        end
    end

    assign fade_level = fade_q;
`else
    assign fade_level = 4'd0;
`endif

    // Moore decode of the screen flags.
    assign is_title     = (state == TITLE);
    assign is_roam      = (state == ROAM);
    assign is_battle    = (state == INTRO) || (state == BATTLE);
    assign is_end       = (state == GAME_OVER) || (state == VICTORY);
    assign player_won   = is_end & won_q;
    assign cur_battle   = cur_q;
    assign battle_begin = begin_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with INTRO_FRAMES=3, RESULT_FRAMES=2.
// A vector table walks the first battle; hand sequences cover the later
// elites, victory, game over, fade ramps and reset mid-battle.
module tb_game_flow_ctrl;

    localparam int INTRO_N  = 3;
    localparam int RESULT_N = 2;
    localparam int NB       = 5;

`ifdef FLOW_FADE_EN
    localparam bit FADE_ON = 1'b1;
`else
    localparam bit FADE_ON = 1'b0;
`endif

    // Expected screen codes (bench-local)
    localparam int ST_T = 0;
    localparam int ST_R = 1;
    localparam int ST_I = 2;
    localparam int ST_B = 3;
    localparam int ST_S = 4;
    localparam int ST_G = 5;
    localparam int ST_V = 6;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       start_battle;
    logic       battle_done;
    logic       battle_won;
    logic       is_title;
    logic       is_roam;
    logic       is_battle;
    logic       is_end;
    logic       player_won;
    logic [2:0] cur_battle;
    logic       battle_begin;
    logic [3:0] fade_level;

    int n_vec;
    int n_bad;

    typedef struct {
        logic rst;
        logic f;
        logic ent;
        logic sb;
        logic bd;
        logic bw;
        int   st;
        int   cur;
        logic pw;
        logic bb;
        int   fade;
    } vec_t;

    vec_t vq[$];

    game_flow_ctrl #(
        .NUM_BATTLES   (NB),
        .INTRO_FRAMES  (INTRO_N),
        .RESULT_FRAMES (RESULT_N)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .start_battle (start_battle),
        .battle_done  (battle_done),
        .battle_won   (battle_won),
        .is_title     (is_title),
        .is_roam      (is_roam),
        .is_battle    (is_battle),
        .is_end       (is_end),
        .player_won   (player_won),
        .cur_battle   (cur_battle),
        .battle_begin (battle_begin),
        .fade_level   (fade_level)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // Drive one Clk of inputs, then sample just after the edge.
    task automatic step(input logic rst, input logic f, input logic ent,
                        input logic sb, input logic bd, input logic bw);
        Reset        = rst;
        frame_clk    = f;
        keycode      = ent ? 8'h28 : 8'h00;
        start_battle = sb;
        battle_done  = bd;
        battle_won   = bw;
        @(posedge Clk);
        #1;
    endtask

    // One frame_clk rising edge; the edge takes effect on the second Clk.
    task automatic frame_pulse();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int st, input int cur,
                         input logic pw, input logic bb, input int fade);
        logic et, er, eb, ee;
        int   ef;
        et = (st == ST_T);
        er = (st == ST_R);
        eb = (st == ST_I) || (st == ST_B);
        ee = (st == ST_G) || (st == ST_V);
        ef = FADE_ON ? fade : 0;
        n_vec++;
        if (is_title !== et || is_roam !== er || is_battle !== eb ||
            is_end !== ee || player_won !== pw || cur_battle !== 3'(cur) ||
            battle_begin !== bb || fade_level !== 4'(ef)) begin
            n_bad++;
            $display("FAIL %s: got title=%b roam=%b battle=%b end=%b won=%b cur=%0d begin=%b fade=%0d, need title=%b roam=%b battle=%b end=%b won=%b cur=%0d begin=%b fade=%0d",
                     name, is_title, is_roam, is_battle, is_end, player_won,
                     cur_battle, battle_begin, fade_level,
                     et, er, eb, ee, pw, cur, bb, ef);
        end
    endtask

    task automatic add(input logic rst, input logic f, input logic ent,
                       input logic sb, input logic bd, input logic bw,
                       input int st, input int cur, input logic pw,
                       input logic bb, input int fade);
        vec_t v;
        v.rst = rst; v.f = f; v.ent = ent; v.sb = sb; v.bd = bd; v.bw = bw;
        v.st = st; v.cur = cur; v.pw = pw; v.bb = bb; v.fade = fade;
        vq.push_back(v);
    endtask

    // Full battle from ROAM at elite index cur, ending wherever the result leads.
    task automatic run_battle(input logic won, input int cur);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rb_intro_entry", ST_I, cur, 1'b0, 1'b0, 0);
        frame_pulse();
        check("rb_intro_edge1", ST_I, cur, 1'b0, 1'b0, 1);
        frame_pulse();
        check("rb_intro_edge2", ST_I, cur, 1'b0, 1'b0, 2);
        frame_pulse();
        check("rb_battle_begin", ST_B, cur, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rb_begin_drop", ST_B, cur, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, won);
        check("rb_result", ST_S, cur, 1'b0, 1'b0, 0);
        frame_pulse();
        check("rb_result_edge1", ST_S, cur, 1'b0, 1'b0, 0);
        frame_pulse();
        if (!won) begin
            check("rb_game_over", ST_G, cur, 1'b0, 1'b0, 0);
        end else if (cur == NB - 1) begin
            check("rb_victory", ST_V, cur, 1'b1, 1'b0, 0);
        end else begin
            check("rb_back_roam", ST_R, cur + 1, 1'b0, 1'b0, 15);
            frame_pulse();
            check("rb_roam_fade", ST_R, cur + 1, 1'b0, 1'b0, 14);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
        start_battle = 1'b0; battle_done = 1'b0; battle_won = 1'b0;

        //   rst f  ent sb bd bw   state cur pw bb fade
        add(1, 0, 0, 0, 0, 0,   ST_T, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,   ST_T, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   ST_T, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   ST_R, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 1, 0, 0, 0, ST_R, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   ST_R, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   ST_R, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   ST_R, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1,   ST_R, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,   ST_I, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   ST_I, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   ST_I, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0,   ST_I, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0,   ST_I, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0, 0,   ST_I, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   ST_B, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,   ST_B, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   ST_B, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1,   ST_S, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   ST_S, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   ST_S, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   ST_S, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   ST_R, 1, 0, 0, 15);
        add(0, 0, 0, 0, 0, 0,   ST_R, 1, 0, 0, 15);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].f, vq[i].ent, vq[i].sb, vq[i].bd, vq[i].bw);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].cur, vq[i].pw,
                  vq[i].bb, vq[i].fade);
        end

        // Elites 1..4 won; fade sweep after returning at elite 3
        run_battle(1'b1, 1);
        run_battle(1'b1, 2);
        for (int i = 1; i <= 15; i++) begin
            frame_pulse();
            check($sformatf("fade_down%0d", i), ST_R, 3, 1'b0, 1'b0,
                  (14 - i > 0) ? 14 - i : 0);
        end
        run_battle(1'b1, 3);
        run_battle(1'b1, 4);

        // Victory screen ignores start_battle, ENTER returns to title
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("victory_hold", ST_V, 4, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        check("victory_enter", ST_T, 0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("title_idle", ST_T, 0, 1'b0, 1'b0, 0);

        // Lose at elite 1 -> game over
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        check("title_to_roam", ST_R, 0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_battle(1'b1, 0);
        run_battle(1'b0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("game_over_hold", ST_G, 1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        check("game_over_enter", ST_T, 0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Reset held two Clk in the middle of a battle
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_battle(1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame_pulse();
        frame_pulse();
        frame_pulse();
        check("pre_reset_battle", ST_B, 1, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_cycle1", ST_T, 0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_cycle2", ST_T, 0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_reset", ST_T, 0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
